// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared audio types for the I2S receive path and its downstream buffers.
//   SAMPLE_WIDTH    : bits per channel sample
//   sample_t        : one signed channel sample
//   stereo_sample_t : packed {left, right} pair, one FIFO storage entry
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_sample_t;

endpackage

// File: rtl/stereo_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// stereo_sample_fifo_if
// Bundles every non-clock/reset signal of stereo_sample_fifo.
//   Producer side : left_sample_in, right_sample_in, new_sample_in
//   Consumer side : left_sample_out, right_sample_out, valid_out, ready_in
//   Status        : count_out, high_water_out, overflow_out,
//                   overflow_count_out (only with STEREO_SAMPLE_FIFO_OVF_COUNT_EN)
// Modports: slave = the FIFO itself, master = whoever drives/observes it.
// ---------------------------------------------------------------------------
interface stereo_sample_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [WIDTH-1:0] left_sample_in;
    logic signed [WIDTH-1:0] right_sample_in;
    logic                    new_sample_in;
    logic signed [WIDTH-1:0] left_sample_out;
    logic signed [WIDTH-1:0] right_sample_out;
    logic                    valid_out;
    logic                    ready_in;
    logic [CW-1:0]           count_out;
    logic [CW-1:0]           high_water_out;
    logic                    overflow_out;
`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
    logic [15:0]             overflow_count_out;
`endif

    modport slave (
        input  left_sample_in, right_sample_in, new_sample_in, ready_in,
        output left_sample_out, right_sample_out, valid_out,
               count_out, high_water_out, overflow_out
`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
        , output overflow_count_out
`endif
    );

    modport master (
        output left_sample_in, right_sample_in, new_sample_in, ready_in,
        input  left_sample_out, right_sample_out, valid_out,
               count_out, high_water_out, overflow_out
`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
        , input overflow_count_out
`endif
    );

endinterface

// File: rtl/stereo_sample_fifo_mem.sv
// ---------------------------------------------------------------------------
// stereo_fifo_mem
// DEPTH x stereo_sample_t storage array for stereo_sample_fifo.
//   clock_in : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : pair to store
//   raddr_i  : read address (asynchronous read)
//   rdata_o  : pair at raddr_i
// Contents are not reset; the owner tracks which entries are valid.
// ---------------------------------------------------------------------------
module stereo_fifo_mem
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clock_in,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  stereo_sample_t wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output stereo_sample_t rdata_o
);

    stereo_sample_t mem_q [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clock_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read gives the FIFO its fall-through head.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stereo_sample_fifo.sv
// ---------------------------------------------------------------------------
// stereo_sample_fifo
// First-word-fall-through FIFO of stereo sample pairs between the I2S
// receiver and downstream consumers (valid/ready on the read side).
//   clock_in : system clock
//   reset_in : asynchronous active-high reset
//   bus      : stereo_sample_fifo_if.slave (samples in, head out, status)
// Optional feature macro: STEREO_SAMPLE_FIFO_OVF_COUNT_EN adds a saturating
// 16-bit count of dropped pairs on bus.overflow_count_out.
// WIDTH must equal audio_pkg::SAMPLE_WIDTH since entries are stereo_sample_t.
// ---------------------------------------------------------------------------
module stereo_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    stereo_sample_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  high_q, high_d;
    logic           ovf_q;
    logic           full, empty, push, pop, drop;
    stereo_sample_t head, wdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = bus.new_sample_in && (!full || pop);
    assign drop  = bus.new_sample_in && full && !pop;

    assign wdata.left  = bus.left_sample_in;
    assign wdata.right = bus.right_sample_in;

    stereo_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clock_in (clock_in),
        .we_i     (push),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (wdata),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (head)
    );

    // Next occupancy and the high-water mark it may raise.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        high_d = (count_d > high_q) ? count_d : high_q;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            high_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            high_q  <= high_d;
            ovf_q   <= drop;
        end
    end

`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    // Dropped-pair counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign bus.overflow_count_out = ovf_cnt_q;
`endif

    // Head is gated to zero when empty so stale memory never leaks out.
    assign bus.left_sample_out  = empty ? WIDTH'(0) : head.left;
    assign bus.right_sample_out = empty ? WIDTH'(0) : head.right;
    assign bus.valid_out        = !empty;
    assign bus.count_out        = count_q;
    assign bus.high_water_out   = high_q;
    assign bus.overflow_out     = ovf_q;

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_stereo_sample_fifo
// Directed self-checking bench for stereo_sample_fifo (DEPTH=16, WIDTH=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_stereo_sample_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic clock_in = 1'b0;
    logic reset_in = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    stereo_sample_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    stereo_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of producer/consumer activity, end 1 unit past the edge.
    task automatic applyStimulus(input logic push, input int l, input int r, input logic rdy);
        bus.new_sample_in   = push;
        bus.left_sample_in  = 16'(l);
        bus.right_sample_in = 16'(r);
        bus.ready_in        = rdy;
        @(posedge clock_in);
        #1;
        bus.new_sample_in = 1'b0;
        bus.ready_in      = 1'b0;
    endtask

    task automatic checkHead(input string tag, input int l, input int r);
        checkOutput({tag, "_valid"}, 16'(bus.valid_out), 16'd1);
        checkOutput({tag, "_left"},  bus.left_sample_out,  16'(l));
        checkOutput({tag, "_right"}, bus.right_sample_out, 16'(r));
    endtask

    initial begin
        bus.new_sample_in   = 1'b0;
        bus.ready_in        = 1'b0;
        bus.left_sample_in  = '0;
        bus.right_sample_in = '0;

        // Reset state
        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("rst_count", 16'(bus.count_out), 16'd0);
        checkOutput("rst_valid", 16'(bus.valid_out), 16'd0);
        checkOutput("rst_left",  bus.left_sample_out, 16'd0);
        checkOutput("rst_high",  16'(bus.high_water_out), 16'd0);
        checkOutput("rst_ovf",   16'(bus.overflow_out), 16'd0);
`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
        checkOutput("rst_ovfcnt", bus.overflow_count_out, 16'd0);
`endif
        reset_in = 1'b0;

        // Three pushes with consumer stalled
        applyStimulus(1'b1, 100, -100, 1'b0);
        checkHead("lat1", 100, -100);
        applyStimulus(1'b1, 200, -200, 1'b0);
        applyStimulus(1'b1, 300, -300, 1'b0);
        checkOutput("p3_count", 16'(bus.count_out), 16'd3);
        checkOutput("p3_high",  16'(bus.high_water_out), 16'd3);
        checkHead("p3_head", 100, -100);

        // Drain in order
        for (int k = 1; k <= 3; k++) begin
            checkHead("pop", k * 100, -k * 100);
            applyStimulus(1'b0, 0, 0, 1'b1);
        end
        checkOutput("drained_valid", 16'(bus.valid_out), 16'd0);
        checkOutput("drained_left",  bus.left_sample_out, 16'd0);
        checkOutput("drained_right", bus.right_sample_out, 16'd0);
        checkOutput("drained_count", 16'(bus.count_out), 16'd0);

        // ready_in while empty does nothing
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("empty_rdy_count", 16'(bus.count_out), 16'd0);
        checkOutput("empty_rdy_high",  16'(bus.high_water_out), 16'd3);

        // Fill to DEPTH, then overflow
        for (int k = 1; k <= DEPTH; k++) applyStimulus(1'b1, k, -k, 1'b0);
        checkOutput("full_count", 16'(bus.count_out), 16'd16);
        checkOutput("full_high",  16'(bus.high_water_out), 16'd16);
        checkOutput("full_ovf0",  16'(bus.overflow_out), 16'd0);
        applyStimulus(1'b1, 32'h7FFF, 32'h8000, 1'b0);
        checkOutput("ovf_pulse", 16'(bus.overflow_out), 16'd1);
        checkOutput("ovf_count", 16'(bus.count_out), 16'd16);
`ifdef STEREO_SAMPLE_FIFO_OVF_COUNT_EN
        checkOutput("ovf_cnt", bus.overflow_count_out, 16'd1);
`endif
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("ovf_clear", 16'(bus.overflow_out), 16'd0);
        checkHead("ovf_head", 1, -1);

        // Full with simultaneous push and pop
        applyStimulus(1'b1, 555, -555, 1'b1);
        checkOutput("fullpp_ovf",   16'(bus.overflow_out), 16'd0);
        checkOutput("fullpp_count", 16'(bus.count_out), 16'd16);
        for (int k = 2; k <= DEPTH; k++) begin
            checkHead("drain", k, -k);
            applyStimulus(1'b0, 0, 0, 1'b1);
        end
        checkHead("drain_last", 555, -555);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("drain_valid", 16'(bus.valid_out), 16'd0);
        checkOutput("drain_count", 16'(bus.count_out), 16'd0);

        // Fresh reset, then 40-pair stream with push+pop every cycle
        reset_in = 1'b1;
        #2;
        reset_in = 1'b0;
        checkOutput("rst2_high", 16'(bus.high_water_out), 16'd0);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) checkHead("stream", 3 * (k - 1), -7 * (k - 1));
            applyStimulus(1'b1, 3 * k, -7 * k, 1'b1);
            checkOutput("stream_count", 16'(bus.count_out), 16'd1);
        end
        checkHead("stream_last", 120, -280);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("stream_empty", 16'(bus.valid_out), 16'd0);
        checkOutput("stream_high",  16'(bus.high_water_out), 16'd1);

        // Asynchronous reset mid-stream with five pairs queued
        for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 1000 + k, -1000 - k, 1'b0);
        checkOutput("pre_arst_count", 16'(bus.count_out), 16'd5);
        #3;
        reset_in = 1'b1;
        #1;
        checkOutput("arst_count", 16'(bus.count_out), 16'd0);
        checkOutput("arst_valid", 16'(bus.valid_out), 16'd0);
        checkOutput("arst_left",  bus.left_sample_out, 16'd0);
        checkOutput("arst_right", bus.right_sample_out, 16'd0);
        checkOutput("arst_high",  16'(bus.high_water_out), 16'd0);
        checkOutput("arst_ovf",   16'(bus.overflow_out), 16'd0);
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        applyStimulus(1'b1, 42, -42, 1'b0);
        checkOutput("post_arst_count", 16'(bus.count_out), 16'd1);
        checkHead("post_arst", 42, -42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
